// File: rtl/bcd_count_source_pkg.sv
// bcd_count_source_pkg: BCD digit type, limits and default timing shared with the display stage
package bcd_count_source_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd2_t;
  localparam bcd_digit_t MAX_TENS = 4'd9;
  localparam bcd_digit_t MAX_ONES = 4'd9;
  localparam int TICK_DIV_DEFAULT = 50_000_000;
  localparam int DB_CYCLES_DEFAULT = 1_000_000;
  // One up/down step of a 00-99 BCD count, wrapping at both ends
  function automatic bcd2_t bcd_step(input bcd2_t c, input logic up);
    bcd2_t n;
    if (up) begin
      n.ones = (c.ones == MAX_ONES) ? 4'd0 : c.ones + 4'd1;
      n.tens = (c.ones != MAX_ONES) ? c.tens : (c.tens == MAX_TENS) ? 4'd0 : c.tens + 4'd1;
    end else begin
      n.ones = (c.ones == 4'd0) ? MAX_ONES : c.ones - 4'd1;
      n.tens = (c.ones != 4'd0) ? c.tens : (c.tens == 4'd0) ? MAX_TENS : c.tens - 4'd1;
    end
    return n;
  endfunction
  function automatic logic [6:0] bcd_to_bin(input bcd2_t c);
    return {3'd0, c.tens} * 7'd10 + {3'd0, c.ones};
  endfunction
endpackage

// File: rtl/bcd_count_source_debounce.sv
// button_debounce: 2-FF synchronizer, stability filter and single-cycle press pulse
module button_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  logic sync1_q, sync2_q, level_q, level_d, press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    level_d = level_q;
    cnt_d = '0;
    if (sync2_q != level_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        cnt_d = '0;
      end
    end
    press_d = level_d & ~level_q;
  end
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q <= cnt_d;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/bcd_count_source.sv
// bcd_count_source: 1 Hz prescaled two-digit BCD up/down counter with run/pause and clear buttons
module bcd_count_source
  import bcd_count_source_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_clr,
  input  logic        sw_dir,
  output logic [11:0] bcd,
  output logic [6:0]  count_bin,
  output logic        running,
  output logic        tick
);
  localparam int PW = $clog2(TICK_DIV);
  logic run_press, clr_press;
  logic dir1_q, dir_q;
  logic running_q, running_d;
  logic [PW-1:0] pre_q, pre_d;
  bcd2_t cnt_q, cnt_d;
  logic [6:0] bin_q, bin_d;
  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk_50MHz(clk_50MHz), .reset(reset), .btn(btn_run), .press(run_press)
  );
  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk_50MHz(clk_50MHz), .reset(reset), .btn(btn_clr), .press(clr_press)
  );
  // Clear wins over a coincident tick; run and clear act independently
  always_comb begin
    tick = running_q && (pre_q == PW'(TICK_DIV - 1));
    running_d = running_q ^ run_press;
    pre_d = (clr_press || tick) ? '0 : running_q ? pre_q + 1'b1 : pre_q;
    cnt_d = clr_press ? '0 : tick ? bcd_step(cnt_q, dir_q) : cnt_q;
    bin_d = bcd_to_bin(cnt_d);
  end
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      dir1_q <= 1'b0;
      dir_q <= 1'b0;
      running_q <= 1'b1;
      pre_q <= '0;
      cnt_q <= '0;
      bin_q <= '0;
    end else begin
      dir1_q <= sw_dir;
      dir_q <= dir1_q;
      running_q <= running_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      bin_q <= bin_d;
    end
  end
  assign bcd = {4'd0, cnt_q.tens, cnt_q.ones};
  assign count_bin = bin_q;
  assign running = running_q;
endmodule

// File: tb/tb_bcd_count_source.sv
// tb_bcd_count_source: directed vector table plus hand sequences for run, clear and reset corners
module tb_bcd_count_source;
  logic clk_50MHz = 1'b0;
  logic reset, btn_run, btn_clr, sw_dir;
  logic [11:0] bcd;
  logic [6:0] count_bin;
  logic running, tick;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic        dir;
    int          adv;
    logic [11:0] bcd;
    logic [6:0]  bin;
    logic        tick;
  } vec_t;
  vec_t vt[14];

  bcd_count_source #(.TICK_DIV(10), .DB_CYCLES(4)) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .btn_run(btn_run), .btn_clr(btn_clr),
    .sw_dir(sw_dir), .bcd(bcd), .count_bin(count_bin), .running(running), .tick(tick)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  task automatic adv(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [11:0] eb, input logic [6:0] en,
                         input logic er, input logic et);
    chk({nm, ".bcd"}, bcd, eb);
    chk({nm, ".bin"}, {5'd0, count_bin}, {5'd0, en});
    chk({nm, ".running"}, {11'd0, running}, {11'd0, er});
    chk({nm, ".tick"}, {11'd0, tick}, {11'd0, et});
  endtask

  initial begin
    vt[0]  = '{1'b1, 0,   12'h000, 7'd0,  1'b0};
    vt[1]  = '{1'b1, 9,   12'h000, 7'd0,  1'b1};
    vt[2]  = '{1'b1, 1,   12'h001, 7'd1,  1'b0};
    vt[3]  = '{1'b1, 10,  12'h002, 7'd2,  1'b0};
    vt[4]  = '{1'b1, 70,  12'h009, 7'd9,  1'b0};
    vt[5]  = '{1'b1, 10,  12'h010, 7'd10, 1'b0};
    vt[6]  = '{1'b1, 890, 12'h099, 7'd99, 1'b0};
    vt[7]  = '{1'b1, 9,   12'h099, 7'd99, 1'b1};
    vt[8]  = '{1'b1, 1,   12'h000, 7'd0,  1'b0};
    vt[9]  = '{1'b0, 10,  12'h099, 7'd99, 1'b0};
    vt[10] = '{1'b0, 10,  12'h098, 7'd98, 1'b0};
    vt[11] = '{1'b0, 80,  12'h090, 7'd90, 1'b0};
    vt[12] = '{1'b0, 10,  12'h089, 7'd89, 1'b0};
    vt[13] = '{1'b1, 10,  12'h090, 7'd90, 1'b0};
    reset = 1'b1; btn_run = 1'b0; btn_clr = 1'b0; sw_dir = 1'b1;
    adv(3);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      sw_dir = vt[i].dir;
      adv(vt[i].adv);
      chk_all($sformatf("vec%0d", i), vt[i].bcd, vt[i].bin, 1'b1, vt[i].tick);
    end
    // short run press is filtered; long press pauses with prescaler held at 5
    btn_run = 1'b1; adv(2); btn_run = 1'b0; adv(6);
    chk_all("short_run", 12'h090, 7'd90, 1'b1, 1'b0);
    btn_run = 1'b1; adv(7);
    chk_all("pause", 12'h091, 7'd91, 1'b0, 1'b0);
    adv(1); btn_run = 1'b0; adv(30);
    chk_all("paused_hold", 12'h091, 7'd91, 1'b0, 1'b0);
    btn_run = 1'b1; adv(7);
    chk_all("resume", 12'h091, 7'd91, 1'b1, 1'b0);
    adv(1); btn_run = 1'b0; adv(3);
    chk_all("resume_tick", 12'h091, 7'd91, 1'b1, 1'b1);
    adv(1);
    chk_all("resume_step", 12'h092, 7'd92, 1'b1, 1'b0);
    // clear mid-period restarts prescaler from 0
    btn_clr = 1'b1; adv(7);
    chk_all("clear", 12'h000, 7'd0, 1'b1, 1'b0);
    adv(1); btn_clr = 1'b0; adv(8);
    chk_all("clear_tick", 12'h000, 7'd0, 1'b1, 1'b1);
    adv(1);
    chk_all("clear_step", 12'h001, 7'd1, 1'b1, 1'b0);
    // clear pulse coincident with tick at 45
    adv(443); btn_clr = 1'b1; adv(6);
    chk_all("clr_tick45", 12'h045, 7'd45, 1'b1, 1'b1);
    adv(1);
    chk_all("clr_wins", 12'h000, 7'd0, 1'b1, 1'b0);
    btn_clr = 1'b0; adv(9);
    chk_all("clr45_tick", 12'h000, 7'd0, 1'b1, 1'b1);
    adv(1);
    chk_all("clr45_step", 12'h001, 7'd1, 1'b1, 1'b0);
    // simultaneous run and clear
    btn_run = 1'b1; btn_clr = 1'b1; adv(7);
    chk_all("both", 12'h000, 7'd0, 1'b0, 1'b0);
    adv(1); btn_run = 1'b0; btn_clr = 1'b0; adv(20);
    chk_all("both_hold", 12'h000, 7'd0, 1'b0, 1'b0);
    btn_run = 1'b1; adv(7);
    chk_all("both_resume", 12'h000, 7'd0, 1'b1, 1'b0);
    adv(1); btn_run = 1'b0; adv(8);
    chk_all("both_tick", 12'h000, 7'd0, 1'b1, 1'b1);
    adv(1);
    chk_all("both_step", 12'h001, 7'd1, 1'b1, 1'b0);
    // asynchronous reset at 37 with prescaler 6
    adv(366);
    chk_all("pre_reset", 12'h037, 7'd37, 1'b1, 1'b0);
    reset = 1'b1; #1;
    chk_all("async_reset", 12'h000, 7'd0, 1'b1, 1'b0);
    adv(3); reset = 1'b0;
    chk_all("reset_rel", 12'h000, 7'd0, 1'b1, 1'b0);
    adv(9);
    chk_all("rst_tick", 12'h000, 7'd0, 1'b1, 1'b1);
    adv(1);
    chk_all("rst_step", 12'h001, 7'd1, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
